// File: rtl/serializer_pkg.sv
// Shared types and defaults for the output serializer: FSM state encoding,
// default transfer width / divider, and a counter-width helper.
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } ser_state_t;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_CLK_DIV = 4;

    // A counter for a range of one still needs a single bit to exist.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tick_gen.sv
// Free-running divider producing a one-cycle half_tick every CLK_DIV cycles;
// clearing it re-aligns the tick phase to the start of a transfer.
module serial_tick_gen
    import serializer_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic half_tick
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (clear || div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign half_tick = !clear && (div_cnt == LAST);

endmodule

// File: rtl/output_serializer.sv
// Shifts a snapshot of the counter value out MSB first on ser_data/ser_clk, then
// strobes ser_latch. Define OUTPUT_SERIALIZER_PARITY_EN to append an even-parity bit.
module output_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ref_clk,
    input  logic [WIDTH-1:0] value,
    output logic             ser_data,
    output logic             ser_clk,
    output logic             ser_latch,
    output logic             busy
);

`ifdef OUTPUT_SERIALIZER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int BW = $clog2(NBITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

    ser_state_t       state;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] shifted;
    logic [NBITS-1:0] load_word;
    logic [BW-1:0]    bit_cnt;
    logic             pending;
    logic             start;
    logic             half_tick;

`ifdef OUTPUT_SERIALIZER_PARITY_EN
    assign load_word = {value, ^value};
`else
    assign load_word = value;
`endif

    assign start   = (state == IDLE) && (ref_clk || pending);
    assign shifted = shreg << 1;

    serial_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .clear    (start),
        .half_tick(half_tick)
    );

    // Data only moves on the falling half of ser_clk, giving a full half
    // period of setup and hold around every rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            pending   <= 1'b0;
            ser_data  <= 1'b0;
            ser_clk   <= 1'b0;
            ser_latch <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (state != IDLE && ref_clk) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= load_word;
                        pending  <= 1'b0;
                        bit_cnt  <= '0;
                        ser_data <= load_word[NBITS-1];
                        ser_clk  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (half_tick) begin
                        if (!ser_clk) begin
                            ser_clk <= 1'b1;
                        end else begin
                            ser_clk <= 1'b0;
                            shreg   <= shifted;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                ser_data  <= 1'b0;
                                ser_latch <= 1'b1;
                                state     <= LATCH;
                            end else begin
                                ser_data <= shifted[NBITS-1];
                            end
                        end
                    end
                end
                LATCH: begin
                    if (half_tick) begin
                        ser_latch <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_serializer.sv
// Self-checking bench for output_serializer: default-sized and a WIDTH=4/CLK_DIV=1
// instance, compared cycle by cycle against a waveform derived from the transfer timing.
module tb_output_serializer;

`ifdef OUTPUT_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int WA  = 8;
    localparam int CDA = 4;
    localparam int WB  = 4;
    localparam int CDB = 1;
    localparam int TOTAL_A = (2 * (WA + PAR) + 1) * CDA;

    logic clk = 1'b0;
    logic reset;
    logic refA, refB;
    logic [WA-1:0] valueA;
    logic [WB-1:0] valueB;
    logic dataA, sclkA, latchA, busyA;
    logic dataB, sclkB, latchB, busyB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    output_serializer #(.WIDTH(WA), .CLK_DIV(CDA)) dutA (
        .clk(clk), .reset(reset), .ref_clk(refA), .value(valueA),
        .ser_data(dataA), .ser_clk(sclkA), .ser_latch(latchA), .busy(busyA)
    );

    output_serializer #(.WIDTH(WB), .CLK_DIV(CDB)) dutB (
        .clk(clk), .reset(reset), .ref_clk(refB), .value(valueB),
        .ser_data(dataB), .ser_clk(sclkB), .ser_latch(latchB), .busy(busyB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [3:0] outs(input int sel);
        return (sel == 0) ? {busyA, latchA, sclkA, dataA} : {busyB, latchB, sclkB, dataB};
    endfunction

    // Bit stream the external device should receive: value MSB first, then even parity if enabled.
    function automatic logic [15:0] streamOf(input logic [7:0] v, input int w);
        logic [15:0] s;
        logic p;
        p = 1'b0;
        for (int i = 0; i < w; i++) p ^= v[i];
        s = {8'h00, v};
        if (PAR != 0) s = {s[14:0], p};
        return s;
    endfunction

    // Expected {busy, latch, ser_clk, ser_data} in cycle N+t after a start sampled at edge N.
    function automatic logic [3:0] expectedAt(input int t, input logic [15:0] bits, input int nb, input int cd);
        int bitIdx;
        int phase;
        if (t <= 2 * nb * cd) begin
            bitIdx = (t - 1) / (2 * cd);
            phase  = (t - 1) % (2 * cd);
            return {1'b1, 1'b0, (phase >= cd) ? 1'b1 : 1'b0, bits[nb - 1 - bitIdx]};
        end else if (t <= (2 * nb + 1) * cd) begin
            return 4'b1100;
        end
        return 4'b0000;
    endfunction

    task automatic setRef(input int sel, input logic r);
        if (sel == 0) refA = r; else refB = r;
    endtask

    task automatic setValue(input int sel, input logic [7:0] v);
        if (sel == 0) valueA = v; else valueB = v[3:0];
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic [7:0] v);
        setValue(sel, v);
        setRef(sel, 1'b1);
        stepCycle();
        setRef(sel, 1'b0);
    endtask

    // Entered one step after the start edge N; leaves one step after the edge where busy falls.
    task automatic watchTransfer(input int sel, input string name, input logic [7:0] v,
                                 input int p0, input int p1, input int p2,
                                 input int changeAt, input logic [7:0] newVal);
        int nb, cd, total, rises;
        logic [15:0] bits, captured;
        logic [3:0] o;
        logic prevClk;
        nb       = ((sel == 0) ? WA : WB) + PAR;
        cd       = (sel == 0) ? CDA : CDB;
        total    = (2 * nb + 1) * cd;
        bits     = streamOf(v, (sel == 0) ? WA : WB);
        captured = '0;
        rises    = 0;
        prevClk  = 1'b0;
        for (int t = 1; t <= total + 1; t++) begin
            o = outs(sel);
            checkOutput($sformatf("%s_t%0d", name, t), o, expectedAt(t, bits, nb, cd));
            if (o[1] && !prevClk) begin
                captured = {captured[14:0], o[0]};
                rises++;
            end
            prevClk = o[1];
            if (t <= total) begin
                setRef(sel, (t == p0) || (t == p1) || (t == p2));
                if (t == changeAt) setValue(sel, newVal);
                stepCycle();
            end
        end
        setRef(sel, 1'b0);
        checkOutput({name, "_word"}, captured, bits);
        checkOutput({name, "_rises"}, rises, nb);
    endtask

    initial begin
        logic [7:0] rv;
        int ca;
        reset  = 1'b0;
        refA   = 1'b0;
        refB   = 1'b0;
        valueA = '0;
        valueB = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_A", outs(0), 4'b0000);
        checkOutput("reset_B", outs(1), 4'b0000);
        reset = 1'b1;
        stepCycle();

        $display("[TB] single transfer of A5");
        applyStimulus(0, 8'hA5);
        watchTransfer(0, "a5", 8'hA5, 0, 0, 0, 0, 8'h00);
        repeat (2) stepCycle();

        $display("[TB] pending absorption with mid-transfer value change");
        applyStimulus(0, 8'hA5);
        watchTransfer(0, "pend_a5", 8'hA5, 10, 30, TOTAL_A, 20, 8'h3C);
        stepCycle();
        watchTransfer(0, "pend_3c", 8'h3C, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < TOTAL_A + 4; i++) begin
            checkOutput("no_third_busy", busyA, 1'b0);
            stepCycle();
        end

        $display("[TB] constant patterns");
        applyStimulus(0, 8'h00);
        watchTransfer(0, "zeros", 8'h00, 0, 0, 0, 0, 8'h00);
        stepCycle();
        applyStimulus(0, 8'hFF);
        watchTransfer(0, "ones", 8'hFF, 0, 0, 0, 0, 8'h00);
        stepCycle();

        $display("[TB] reset during transfer");
        applyStimulus(0, 8'h5A);
        for (int t = 1; t < 20; t++) begin
            refA = (t == 5);
            stepCycle();
        end
        refA = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset_A", outs(0), 4'b0000);
        checkOutput("midreset_B", outs(1), 4'b0000);
        #3 reset = 1'b1;
        stepCycle();
        for (int i = 0; i < 12; i++) begin
            checkOutput("post_reset_idle", outs(0), 4'b0000);
            stepCycle();
        end
        applyStimulus(0, 8'hC3);
        watchTransfer(0, "after_reset", 8'hC3, 0, 0, 0, 0, 8'h00);
        stepCycle();

        $display("[TB] narrow fast instance");
        applyStimulus(1, 8'h09);
        watchTransfer(1, "b_1001", 8'h09, 0, 0, 0, 0, 8'h00);
        stepCycle();

        $display("[TB] randomized transfers");
        for (int i = 0; i < 6; i++) begin
            rv = 8'($urandom);
            ca = $urandom_range(1, TOTAL_A - 1);
            applyStimulus(0, rv);
            watchTransfer(0, $sformatf("rndA%0d", i), rv, 0, 0, 0, ca, 8'($urandom));
            repeat ($urandom_range(0, 3)) begin
                checkOutput("rnd_idle_A", busyA, 1'b0);
                stepCycle();
            end
            rv = 8'($urandom_range(0, 15));
            ca = $urandom_range(1, 8);
            applyStimulus(1, rv);
            watchTransfer(1, $sformatf("rndB%0d", i), rv, 0, 0, 0, ca, 8'($urandom_range(0, 15)));
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
